// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type, constants and helpers for the radix-2 FFT
package fft_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STAGE,
    S_BFLY,
    S_UNLOAD,
    S_DONE
  } fft_state_t;

  localparam int TW_EXTRA = 2;  // twiddle word width is Q + TW_EXTRA (sign + integer bit)
  localparam int BFLY_LAT = 0;  // fft_butterfly is purely combinational
  localparam real PI = 3.14159265358979323846;

  function automatic int unsigned bitrev(input int unsigned v, input int bits);
    int unsigned r;
    r = 0;
    for (int i = 0; i < bits; i++) begin
      r = (r << 1) | ((v >> i) & 32'd1);
    end
    return r;
  endfunction

  // Edges from the start-accepting edge to the edge that raises done.
  function automatic int FFT_CYCLES(input int log2pts, input int rd_lat);
    int p;
    p = 1 << log2pts;
    return (p + rd_lat) + log2pts * (p / 2 * (1 + BFLY_LAT) + 1) + p + 1;
  endfunction

  function automatic real taylor_sin(input real x);
    real term;
    real sum;
    term = x;
    sum = x;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum = sum + term;
    end
    return sum;
  endfunction

  function automatic real taylor_cos(input real x);
    real term;
    real sum;
    term = 1.0;
    sum = 1.0;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum = sum + term;
    end
    return sum;
  endfunction

  // Round-to-nearest fixed point conversion with q fractional bits.
  function automatic int tw_fix(input real v, input int q);
    real s;
    s = 1.0;
    for (int i = 0; i < q; i++) begin
      s = s * 2.0;
    end
    if (v >= 0.0) return $rtoi(v * s + 0.5);
    return -$rtoi(-v * s + 0.5);
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - combinational radix-2 butterfly: a +/- W*b
// Optional feature macro: FFT_SCALE_EN halves both outputs.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int N    = 32,
  parameter int Q    = 16,
  parameter int TW_W = Q + TW_EXTRA
) (
  input  logic signed [N-1:0]    a_re,
  input  logic signed [N-1:0]    a_im,
  input  logic signed [N-1:0]    b_re,
  input  logic signed [N-1:0]    b_im,
  input  logic signed [TW_W-1:0] w_re,
  input  logic signed [TW_W-1:0] w_im,
  output logic signed [N-1:0]    ya_re,
  output logic signed [N-1:0]    ya_im,
  output logic signed [N-1:0]    yb_re,
  output logic signed [N-1:0]    yb_im
);

  localparam int PW = 2 * N;

  logic signed [PW-1:0] wr_x, wi_x, br_x, bi_x;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [N-1:0]  t_re, t_im;

  function automatic logic signed [N-1:0] q_shift(input logic signed [PW-1:0] p);
    return N'(p >>> Q);
  endfunction

  assign wr_x = {{(PW - TW_W){w_re[TW_W-1]}}, w_re};
  assign wi_x = {{(PW - TW_W){w_im[TW_W-1]}}, w_im};
  assign br_x = {{(PW - N){b_re[N-1]}}, b_re};
  assign bi_x = {{(PW - N){b_im[N-1]}}, b_im};

  // Each product is kept at full width and truncated on its own before summing.
  assign p_rr = wr_x * br_x;
  assign p_ii = wi_x * bi_x;
  assign p_ri = wr_x * bi_x;
  assign p_ir = wi_x * br_x;

  assign t_re = q_shift(p_rr) - q_shift(p_ii);
  assign t_im = q_shift(p_ri) + q_shift(p_ir);

`ifdef FFT_SCALE_EN
  logic signed [N:0] sa_re, sa_im, sb_re, sb_im;

  // One guard bit so the halved result cannot wrap.
  assign sa_re = {a_re[N-1], a_re} + {t_re[N-1], t_re};
  assign sa_im = {a_im[N-1], a_im} + {t_im[N-1], t_im};
  assign sb_re = {a_re[N-1], a_re} - {t_re[N-1], t_re};
  assign sb_im = {a_im[N-1], a_im} - {t_im[N-1], t_im};

  assign ya_re = sa_re[N:1];
  assign ya_im = sa_im[N:1];
  assign yb_re = sb_re[N:1];
  assign yb_im = sb_im[N:1];
`else
  assign ya_re = a_re + t_re;
  assign ya_im = a_im + t_im;
  assign yb_re = a_re - t_re;
  assign yb_im = a_im - t_im;
`endif

endmodule

// File: rtl/fft_radix2_param.sv
// rtl/fft_radix2_param.sv - in-place radix-2 DIT FFT/IFFT with external input RAM
// Loads bit-reversed, runs LOG2PTS passes of one butterfly per cycle, unloads in natural order.
module fft_radix2_param
  import fft_pkg::*;
#(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int LOG2PTS = 9,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      inverse,
  output logic [LOG2PTS-1:0]        in_addr,
  input  logic signed [N-1:0]       in_real,
  input  logic signed [N-1:0]       in_imag,
  output logic [LOG2PTS-1:0]        out_addr,
  output logic signed [N-1:0]       out_real,
  output logic signed [N-1:0]       out_imag,
  output logic                      out_we,
  output logic                      busy,
  output logic                      done
);

  localparam int AW   = LOG2PTS;
  localparam int P    = 1 << AW;
  localparam int HALF = P / 2;
  localparam int TW_W = Q + TW_EXTRA;
  localparam int CW   = 16;
  localparam logic [CW-1:0] LOAD_LAST = CW'(P - 1 + RD_LAT);

  fft_state_t    state;
  logic [CW-1:0] cnt;
  logic [AW-2:0] bcnt;
  logic [3:0]    stage;
  logic          inv_q;

  logic signed [N-1:0] wram_re [P];
  logic signed [N-1:0] wram_im [P];

  logic signed [TW_W-1:0] tw_cos [HALF];
  logic signed [TW_W-1:0] tw_sin [HALF];

  logic [31:0]            span, pos, jlo;
  logic [AW-1:0]          addr_a, addr_b, wa_addr, ld_idx;
  logic [AW-2:0]          tw_idx;
  logic                   ld_write, we_a, we_b;
  logic signed [N-1:0]    ra_re, ra_im, rb_re, rb_im;
  logic signed [N-1:0]    wa_re, wa_im, wb_re, wb_im;
  logic signed [N-1:0]    ya_re, ya_im, yb_re, yb_im;
  logic signed [TW_W-1:0] w_re, w_im;

  for (genvar k = 0; k < HALF; k++) begin : g_tw
    localparam real ANG   = 2.0 * PI * real'(k) / real'(P);
    localparam int  COS_V = tw_fix(taylor_cos(ANG), Q);
    localparam int  SIN_V = tw_fix(taylor_sin(ANG), Q);
    assign tw_cos[k] = TW_W'(COS_V);
    assign tw_sin[k] = TW_W'(SIN_V);
  end

  // Butterfly b of pass s: group b>>s, offset b&(2^s-1), twiddle step P/2^(s+1).
  always_comb begin
    span   = 32'd1 << stage;
    pos    = 32'(bcnt) & (span - 32'd1);
    jlo    = ((32'(bcnt) >> stage) << (stage + 4'd1)) | pos;
    addr_a = AW'(jlo);
    addr_b = AW'(jlo + span);
    tw_idx = (AW-1)'(pos << (32'(AW - 1) - 32'(stage)));
    if (state == S_UNLOAD) addr_a = cnt[AW-1:0];
  end

  assign w_re = tw_cos[tw_idx];
  assign w_im = inv_q ? tw_sin[tw_idx] : -tw_sin[tw_idx];

  assign ra_re = wram_re[addr_a];
  assign ra_im = wram_im[addr_a];
  assign rb_re = wram_re[addr_b];
  assign rb_im = wram_im[addr_b];

  fft_butterfly #(
    .N   (N),
    .Q   (Q),
    .TW_W(TW_W)
  ) u_bfly (
    .a_re (ra_re),
    .a_im (ra_im),
    .b_re (rb_re),
    .b_im (rb_im),
    .w_re (w_re),
    .w_im (w_im),
    .ya_re(ya_re),
    .ya_im(ya_im),
    .yb_re(yb_re),
    .yb_im(yb_im)
  );

  assign ld_idx   = AW'(cnt - CW'(RD_LAT));
  assign ld_write = (state == S_LOAD) && (cnt >= CW'(RD_LAT));

  always_comb begin
    we_a    = 1'b0;
    we_b    = 1'b0;
    wa_addr = addr_a;
    wa_re   = ya_re;
    wa_im   = ya_im;
    wb_re   = yb_re;
    wb_im   = yb_im;
    if (ld_write) begin
      we_a    = 1'b1;
      wa_addr = AW'(bitrev(32'(ld_idx), AW));
      wa_re   = in_real;
      wa_im   = in_imag;
    end else if (state == S_BFLY) begin
      we_a = 1'b1;
      we_b = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_a) begin
      wram_re[wa_addr] <= wa_re;
      wram_im[wa_addr] <= wa_im;
    end
    if (we_b) begin
      wram_re[addr_b] <= wb_re;
      wram_im[addr_b] <= wb_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_we   <= 1'b0;
      in_addr  <= '0;
      out_addr <= '0;
      out_real <= '0;
      out_imag <= '0;
      cnt      <= '0;
      bcnt     <= '0;
      stage    <= '0;
      inv_q    <= 1'b0;
    end else begin
      done   <= 1'b0;
      out_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            inv_q   <= inverse;
            busy    <= 1'b1;
            cnt     <= '0;
            in_addr <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt < CW'(P - 1)) in_addr <= AW'(cnt + CW'(1));
          cnt <= cnt + CW'(1);
          if (cnt == LOAD_LAST) begin
            stage <= '0;
            state <= S_STAGE;
          end
        end
        S_STAGE: begin
          bcnt  <= '0;
          state <= S_BFLY;
        end
        S_BFLY: begin
          bcnt <= bcnt + (AW-1)'(1);
          if (bcnt == (AW-1)'(HALF - 1)) begin
            if (stage == 4'(AW - 1)) begin
              cnt   <= '0;
              state <= S_UNLOAD;
            end else begin
              stage <= stage + 4'd1;
              state <= S_STAGE;
            end
          end
        end
        S_UNLOAD: begin
          out_we   <= 1'b1;
          out_addr <= cnt[AW-1:0];
          out_real <= ra_re;
          out_imag <= ra_im;
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(P - 1)) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_radix2_param.md
FFT_RADIX2_PARAM -- requirements
Module: fft_radix2_param

Interface
REQ-001 SHALL have parameter N, default 32: data word width, signed two's complement.
REQ-002 SHALL have parameter Q, default 16: fractional bits of the data words.
REQ-003 SHALL have parameter LOG2PTS, default 9: transform length P = 2^LOG2PTS, legal range 3..10.
REQ-004 SHALL have parameter RD_LAT, default 2: read latency in cycles of the external input RAM.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: request a transform; sampled in IDLE only.
REQ-008 SHALL have port inverse, input, 1: 0 selects forward transform, 1 selects inverse; sampled with start.
REQ-009 SHALL have port in_addr, output, LOG2PTS: read address to the external input RAM.
REQ-010 SHALL have ports in_real and in_imag, input, N each: input RAM data, valid RD_LAT cycles after in_addr.
REQ-011 SHALL have ports out_addr, out_real and out_imag, output, LOG2PTS/N/N: result index and data.
REQ-012 SHALL have port out_we, output, 1: out_* valid this cycle; one pulse per bin.
REQ-013 SHALL have ports busy and done, output, 1 each: busy is high from start acceptance to done; done is a one-cycle pulse.

Function
REQ-014 SHALL step through states IDLE -> LOAD -> STAGE -> BFLY -> (STAGE | UNLOAD) -> DONE -> IDLE.
REQ-015 LOAD SHALL read in_addr 0..P-1 and write sample i to working-RAM address bitrev(i, LOG2PTS).
REQ-016 STAGE SHALL run LOG2PTS passes, size = 2,4,..,P, with twiddle index k stepping by P/size per butterfly.
REQ-017 Each butterfly SHALL compute t = W*x[j+h], x[j+h] = x[j]-t, x[j] = x[j]+t, in place.
REQ-018 W SHALL be cos(2πk/P) - j·sin(2πk/P) in forward mode and cos + j·sin in inverse mode.
REQ-019 Products SHALL be full 2N-bit, arithmetically shifted right by Q with truncation; sums SHALL wrap modulo 2^N.
REQ-020 Twiddles SHALL be stored as signed (Q+2)-bit values with Q fractional bits, covering k = 0..P/2-1.
REQ-021 UNLOAD SHALL emit bins 0..P-1 in natural order, each with one out_we pulse; gaps between pulses are permitted.
REQ-022 done SHALL pulse one cycle after the last out_we; busy SHALL fall in the same cycle.
REQ-023 The start-to-done cycle count SHALL be fixed for given parameters and published as package constant FFT_CYCLES.
REQ-024 start asserted while busy SHALL be ignored; start held high in IDLE after done SHALL begin a new transform.

Reset
REQ-025 With rst high at a clock edge, the block SHALL enter IDLE with busy=0, done=0, out_we=0, in_addr=0, out_addr=0, out_real=0, out_imag=0.
REQ-026 rst mid-transform SHALL abort with no further out_we; working-RAM contents are undefined afterwards.

Configuration
REQ-027 With FFT_SCALE_EN defined, each butterfly output SHALL be arithmetically shifted right by 1 (total 1/P scaling); undefined, no scaling is applied.

Structure
REQ-028 Package fft_pkg SHALL hold the state enum, the bitrev function, the FFT_CYCLES function and the twiddle width constant.
REQ-029 The complex multiply-add/sub SHALL be sub-module fft_butterfly (combinational or one register stage, with latency fixed and stated in fft_pkg); twiddle ROM and working RAM are internal.

Verification (LOG2PTS=3, N=32, Q=16)
REQ-030 Impulse x[0]=0x00010000, others 0, forward -> every bin real 0x00010000, imag 0; with FFT_SCALE_EN, 0x00002000.
REQ-031 Constant 1.0 input, forward, no scaling -> bin0 real 0x00080000; bins 1..7 = 0 within ±2 LSB.
REQ-032 x[n]=cos(2πn/8), forward, no scaling -> bins 1 and 7 real 0x00040000 ±4 LSB; all others ≈0.
REQ-033 Forward then inverse with FFT_SCALE_EN on a random input -> x/8 reproduced within ±8 LSB.
REQ-034 start pulsed mid-STAGE -> ignored; exactly 8 out_we pulses and one done; start-to-done equals FFT_CYCLES.
REQ-035 rst asserted during BFLY -> next cycle busy=0, no out_we; a following start completes a correct transform.
